// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: instruction codes and FSM state shared by the fetch stage
package fetch_ctrl_pkg;
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;
   localparam logic [3:0] RNONE   = 4'hF;
   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
endpackage

// File: rtl/fetch_ctrl_ilen_decode.sv
// ilen_decode: instruction layout and byte length from icode
module ilen_decode
   import fetch_ctrl_pkg::*;
(
   input  logic [3:0] icode,
   output logic       need_regids,
   output logic       need_valC,
   output logic       instr_valid,
   output logic [3:0] length
);
   assign need_regids = icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
   assign need_valC   = icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
   assign instr_valid = icode <= IPOPQ;
   assign length      = !instr_valid ? 4'd1 : 4'd1 + (need_regids ? 4'd1 : 4'd0) + (need_valC ? 4'd8 : 4'd0);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: byte-serial instruction fetch FSM with decode and imem range check
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int IMEM_SIZE = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [63:0] pc_i,
   output logic        mem_req_o,
   output logic [63:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [7:0]  mem_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [3:0]  icode_o,
   output logic [3:0]  ifunc_o,
   output logic [3:0]  rA_o,
   output logic [3:0]  rB_o,
   output logic [63:0] valC_o,
   output logic [63:0] valP_o,
   output logic        instr_valid_o,
   output logic        imem_error_o,
   output logic        busy_o
);
   localparam logic [63:0] LIMIT = 64'(IMEM_SIZE);
   state_t      state;
   logic [63:0] pc;
   logic [3:0]  idx;
   logic [3:0]  dec_icode;
   logic [3:0]  dec_len;
   logic [2:0]  vidx;
   logic [63:0] next_addr;
   logic        dec_regids, dec_valc, dec_valid;
   // byte 0 decodes straight off the bus; later bytes use the captured icode
   assign dec_icode = (idx == 4'd0) ? mem_data_i[7:4] : icode_o;
   assign vidx = idx[2:0] - (dec_regids ? 3'd2 : 3'd1);
   assign next_addr = mem_addr_o + 64'd1;
   assign busy_o = state != IDLE;
   assign out_valid_o = state == DONE;
   ilen_decode u_dec (
      .icode       (dec_icode),
      .need_regids (dec_regids),
      .need_valC   (dec_valc),
      .instr_valid (dec_valid),
      .length      (dec_len)
   );
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         pc <= '0;
         idx <= '0;
         mem_req_o <= 1'b0;
         mem_addr_o <= '0;
         icode_o <= '0;
         ifunc_o <= '0;
         rA_o <= RNONE;
         rB_o <= RNONE;
         valC_o <= '0;
         valP_o <= '0;
         instr_valid_o <= 1'b1;
         imem_error_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               pc <= pc_i;
               idx <= '0;
               mem_addr_o <= pc_i;
               icode_o <= '0;
               ifunc_o <= '0;
               rA_o <= RNONE;
               rB_o <= RNONE;
               valC_o <= '0;
               valP_o <= '0;
               instr_valid_o <= 1'b1;
               imem_error_o <= pc_i >= LIMIT;
               mem_req_o <= pc_i < LIMIT;
               state <= (pc_i >= LIMIT) ? DONE : FETCH;
            end
            FETCH: if (mem_ack_i) begin
               if (idx == 4'd0) begin
                  icode_o <= mem_data_i[7:4];
                  ifunc_o <= mem_data_i[3:0];
                  instr_valid_o <= dec_valid;
                  valP_o <= pc + 64'(dec_len);
               end else if (idx == 4'd1 && dec_regids) begin
                  rA_o <= mem_data_i[7:4];
                  rB_o <= mem_data_i[3:0];
               end else if (dec_valc) begin
                  valC_o <= valC_o | (64'(mem_data_i) << {vidx, 3'b000});
               end
               // a following byte past the end of imem ends the fetch with an error
               if (idx + 4'd1 == dec_len) begin
                  mem_req_o <= 1'b0;
                  state <= DONE;
               end else if (next_addr >= LIMIT) begin
                  mem_req_o <= 1'b0;
                  imem_error_o <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + 4'd1;
                  mem_addr_o <= next_addr;
               end
            end
            DONE: if (out_ready_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized and directed fetches checked against a byte-level reference model
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [63:0] pc_in = '0;
   logic        mem_req, mem_ack, out_valid, out_ready = 1'b0;
   logic [63:0] mem_addr, valc, valp;
   logic [7:0]  mem_data;
   logic [3:0]  icode, ifunc, ra, rb;
   logic        iv, err, busy;
   logic [7:0]  mem [0:1023];
   int          delay = 0, wait_cnt = 0, total_acks = 0, nvec = 0, nerr = 0;
   logic        bad_req = 1'b0;
   logic [3:0]  e_icode, e_ifunc, e_ra, e_rb;
   logic [63:0] e_valc, e_valp;
   logic        e_iv, e_err;
   int          e_n;

   always #5 clk = ~clk;

   fetch_ctrl #(.IMEM_SIZE(1024)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .pc_i(pc_in),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .icode_o(icode), .ifunc_o(ifunc), .rA_o(ra), .rB_o(rb),
      .valC_o(valc), .valP_o(valp), .instr_valid_o(iv), .imem_error_o(err), .busy_o(busy)
   );

   assign mem_ack = mem_req && (wait_cnt >= delay);
   assign mem_data = mem[mem_addr[9:0]];

   always @(posedge clk) begin
      wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
      if (mem_req && mem_ack) total_acks <= total_acks + 1;
      if (mem_req && mem_addr >= 64'd1024) bad_req <= 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [210:0] outs();
      return {icode, ifunc, ra, rb, valc, valp, iv, err, mem_req, mem_addr};
   endfunction

   // Reference: walk the instruction bytes using the instruction-format table
   task automatic model(input logic [63:0] pc);
      int len;
      bit regs, cst;
      logic [7:0] b;
      e_icode = 0; e_ifunc = 0; e_ra = 4'hF; e_rb = 4'hF; e_valc = 0; e_valp = 0;
      e_iv = 1; e_err = 0; e_n = 0;
      if (pc >= 64'd1024) begin
         e_err = 1;
         return;
      end
      b = mem[pc[9:0]];
      e_icode = b[7:4];
      e_ifunc = b[3:0];
      case (e_icode)
         4'h0, 4'h1, 4'h9:       begin len = 1;  regs = 0; cst = 0; end
         4'h2, 4'h6, 4'hA, 4'hB: begin len = 2;  regs = 1; cst = 0; end
         4'h7, 4'h8:             begin len = 9;  regs = 0; cst = 1; end
         4'h3, 4'h4, 4'h5:       begin len = 10; regs = 1; cst = 1; end
         default:                begin len = 1;  regs = 0; cst = 0; e_iv = 0; end
      endcase
      e_valp = pc + 64'(len);
      e_n = 1;
      for (int i = 1; i < len; i++) begin
         if (pc + 64'(i) >= 64'd1024) begin
            e_err = 1;
            break;
         end
         e_n++;
         b = mem[10'(pc + 64'(i))];
         if (regs && i == 1) begin
            e_ra = b[7:4];
            e_rb = b[3:0];
         end else if (cst) e_valc = e_valc | (64'(b) << (8 * (i - (regs ? 2 : 1))));
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req"}, 64'(mem_req), 0);
      chk({tag, "_valid"}, 64'(out_valid), 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_icode"}, {icode, ifunc}, 0);
      chk({tag, "_regs"}, {ra, rb}, 64'hFF);
      chk({tag, "_valc"}, valc, 0);
      chk({tag, "_valp"}, valp, 0);
      chk({tag, "_flags"}, {iv, err}, 64'b10);
   endtask

   task automatic run(input logic [63:0] pc, input int d, input int hold);
      int base, cyc;
      logic [210:0] snap;
      model(pc);
      delay = d;
      @(negedge clk);
      base = total_acks;
      start = 1'b1;
      pc_in = pc;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk("out_valid", 64'(out_valid), 1);
      chk("latency", 64'(cyc), 64'(1 + e_n * (d + 1)));
      chk("acks", 64'(total_acks - base), 64'(e_n));
      chk("icode", 64'(icode), 64'(e_icode));
      chk("ifunc", 64'(ifunc), 64'(e_ifunc));
      chk("rA", 64'(ra), 64'(e_ra));
      chk("rB", 64'(rb), 64'(e_rb));
      chk("valC", valc, e_valc);
      chk("valP", valp, e_valp);
      chk("instr_valid", 64'(iv), 64'(e_iv));
      chk("imem_error", 64'(err), 64'(e_err));
      chk("busy", 64'(busy), 1);
      chk("req_done", 64'(mem_req), 0);
      snap = outs();
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            start = 1'b1;
            pc_in = 64'(200 + i);
         end
         @(negedge clk);
         start = 1'b0;
         chk("hold", 64'(outs() == snap), 1);
         chk("hold_valid", 64'(out_valid), 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("to_idle", {out_valid, busy}, 0);
   endtask

   initial begin
      int base, n;
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
      for (int i = 3; i < 10; i++) mem[i] = 8'h00;
      mem[20] = 8'h10;
      mem[22] = 8'hC0;
      mem[1020] = 8'h30; mem[1021] = 8'hF2;
      #12;
      chk_reset("reset");
      @(negedge clk);
      rst = 1'b0;
      run(64'd0, 0, 1);
      run(64'd20, 3, 1);
      run(64'd22, 1, 1);
      run(64'd1024, 0, 1);
      run(64'd1020, 1, 1);
      run(64'd0, 2, 5);
      // asynchronous reset in the middle of a 10-byte fetch
      delay = 0;
      @(negedge clk);
      base = total_acks;
      start = 1'b1;
      pc_in = 64'd0;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (total_acks - base < 3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("acks_before_rst", 64'(total_acks - base), 3);
      #2 rst = 1'b1;
      #1 chk_reset("midrst");
      @(negedge clk);
      rst = 1'b0;
      run(64'd0, 0, 1);
      for (int k = 0; k < 40; k++) run(64'($urandom_range(24, 1023)), $urandom_range(0, 3), 1 + (k % 3));
      chk("no_oob_req", 64'(bad_req), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter IMEM_SIZE, default 1024, instruction memory size in bytes; any byte address >= IMEM_SIZE is an imem error.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 start_i  input  1  fetch request; sampled only in IDLE.
REQ-005 pc_i  input  64  address of instruction to fetch; captured with start_i.
REQ-006 mem_req_o  output  1  byte-read request to instruction memory.
REQ-007 mem_addr_o  output  64  byte address of the current read.
REQ-008 mem_ack_i  input  1  read complete; mem_data_i valid this cycle; may be combinational from mem_req_o.
REQ-009 mem_data_i  input  8  returned byte.
REQ-010 out_valid_o  output  1  fetched instruction available.
REQ-011 out_ready_i  input  1  consumer accepts the instruction.
REQ-012 icode_o, ifunc_o, rA_o, rB_o  output  4 each  decoded instruction fields.
REQ-013 valC_o, valP_o  output  64 each  constant word; address of next sequential instruction.
REQ-014 instr_valid_o, imem_error_o  output  1 each  icode legal; address out of range.
REQ-015 busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, FETCH, DONE.
REQ-017 IDLE: start_i=1 captures pc_i into the PC register and clears the byte index and the result registers -> FETCH; start_i ignored in FETCH and DONE.
REQ-018 FETCH: mem_req_o=1, mem_addr_o=PC+index; on mem_ack_i=1 store mem_data_i and increment index; mem_req_o stays high until ack.
REQ-019 Byte 0: icode=data[7:4], ifunc=data[3:0].
REQ-020 Instruction length in bytes: 0,1,9 -> 1; 2,6,A,B -> 2 (regids); 7,8 -> 9 (valC); 3,4,5 -> 10 (regids+valC); C..F -> invalid, length 1.
REQ-021 Byte 1, when regids present: rA=data[7:4], rB=data[3:0]; otherwise rA=rB=4'hF.
REQ-022 valC bytes are little-endian, least significant first; valC=0 when absent.
REQ-023 valP = PC + length, 64-bit wrap-around.
REQ-024 When the final byte is acked -> DONE.
REQ-025 Invalid icode: instr_valid_o=0; stop after byte 0 -> DONE; valP=PC+1.
REQ-026 Range check before each request: if PC+index >= IMEM_SIZE, assert no request, set imem_error_o=1 -> DONE; the bytes already fetched are kept.
REQ-027 DONE: out_valid_o=1 and all outputs held stable; out_ready_i=1 -> IDLE next cycle.
REQ-028 Minimum latency for a 1-byte instruction with a combinational ack: start_i in cycle 0; req+ack in cycle 1; out_valid_o in cycle 2.
REQ-029 Latency is 1 + number of ack cycles; wait cycles stall only in FETCH.

Reset
REQ-030 rst_i=1 forces IDLE immediately, including mid-fetch; the partial instruction is discarded.
REQ-031 Reset values: mem_req_o=0, out_valid_o=0, busy_o=0, mem_addr_o=0, icode_o=ifunc_o=0, rA_o=rB_o=4'hF, valC_o=valP_o=0, instr_valid_o=1, imem_error_o=0.

Structure
REQ-032 icode constants (IHALT..IPOPQ) live in the shared define file with the fetch stage; no local literals.
REQ-033 One combinational sub-module, ilen_decode: inputs icode; outputs need_regids, need_valC, instr_valid, length[3:0].

Verification
REQ-034 Memory bytes 30 F2 0A 00 00 00 00 00 00 00 at 0; start pc=0 -> icode=3, ifunc=0, rA=F, rB=2, valC=0xA, valP=10, 10 acks.
REQ-035 Byte 10 at pc=20; ack delayed 3 cycles per byte -> icode=1, rA=rB=F, valP=21, out_valid_o asserted 1 cycle after the last ack.
REQ-036 Byte C0 at pc=22 -> instr_valid_o=0, valP=23, exactly 1 read.
REQ-037 start pc=1024 -> no mem_req_o, imem_error_o=1; irmovq at pc=1020 -> 4 acks, then imem_error_o=1.
REQ-038 out_ready_i=0 for 5 cycles in DONE -> outputs stable, start_i pulses ignored; release -> IDLE.
REQ-039 rst_i asserted after byte 3 of a 10-byte fetch -> mem_req_o=0 immediately, all outputs at reset values; the next start fetches cleanly.
